// File: rtl/capture_uart_uploader.sv
// capture_uart_uploader
// Drains one captured frame from the capture FIFO and sends it to the host as
// an 8N1 UART stream: header, 16-bit length, payload, 8-bit payload checksum.
module capture_uart_uploader #(
   parameter int unsigned CLK_DIV  = 434,
   parameter logic [7:0]  HDR_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT  = 4096
) (
   input  logic       aclk,
   input  logic       rstn,
   input  logic       start,
   input  logic [9:0] frame_len,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_q,
   output logic       fifo_rdreq,
   output logic       txd,
   output logic       busy,
   output logic       done,
   output logic       frame_err
);

   localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE,
      HDR,
      LEN_H,
      LEN_L,
      RD,
      RD_WAIT,
      PAY,
      CSUM,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   // ------------------------------------------------------------------
   // UART transmitter
   // ------------------------------------------------------------------
   logic [8:0]       tx_shift;   // remaining data bits, then the stop bit
   logic [3:0]       tx_bit;     // 0 = start bit, 1..8 = data, 9 = stop
   logic [DIV_W-1:0] tx_div;
   logic             tx_active;
   logic             tx_idle;
   logic             tx_load;
   logic [7:0]       tx_data;

   // Idle is also flagged on the final stop-bit cycle so a new byte can be
   // loaded back-to-back without an idle gap on the line.
   assign tx_idle = !tx_active || ((tx_bit == 4'd9) && (tx_div == DIV_LAST));

   // Bit timing and serialisation; a load always wins over the running byte.
   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         txd       <= 1'b1;
         tx_shift  <= '0;
         tx_bit    <= '0;
         tx_div    <= '0;
         tx_active <= 1'b0;
      end else if (tx_load) begin
         txd       <= 1'b0;
         tx_shift  <= {1'b1, tx_data};
         tx_bit    <= '0;
         tx_div    <= '0;
         tx_active <= 1'b1;
      end else if (tx_active) begin
         if (tx_div == DIV_LAST) begin
            tx_div <= '0;
            if (tx_bit == 4'd9) begin
               tx_active <= 1'b0;
            end else begin
               txd      <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
               tx_bit   <= tx_bit + 4'd1;
            end
         end else begin
            tx_div <= tx_div + DIV_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame sequencer
   // ------------------------------------------------------------------
   logic [9:0]         len;
   logic [9:0]         cnt;
   logic [7:0]         csum;
   logic [STALL_W-1:0] stall;
   logic               csum_sent;

   logic accept;
   logic take_byte;
   logic stall_inc;
   logic abort;
   logic csum_arm;

   // State register.
   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-cycle strobes for the UART, FIFO and datapath.
   always_comb begin
      state_nxt  = state;
      tx_load    = 1'b0;
      tx_data    = 8'h00;
      fifo_rdreq = 1'b0;
      accept     = 1'b0;
      take_byte  = 1'b0;
      stall_inc  = 1'b0;
      abort      = 1'b0;
      csum_arm   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = HDR;
            end
         end
         HDR: begin
            if (tx_idle) begin
               tx_load   = 1'b1;
               tx_data   = HDR_BYTE;
               state_nxt = LEN_H;
            end
         end
         LEN_H: begin
            if (tx_idle) begin
               tx_load   = 1'b1;
               tx_data   = {6'b000000, len[9:8]};
               state_nxt = LEN_L;
            end
         end
         LEN_L: begin
            if (tx_idle) begin
               tx_load   = 1'b1;
               tx_data   = len[7:0];
               state_nxt = (len == 10'd0) ? CSUM : RD;
            end
         end
         RD: begin
            // Stall time is counted even while the previous byte is still
            // shifting, so an abort can leave that byte to finish on its own.
            if (fifo_empty) begin
               if (stall == STALL_LAST) begin
                  abort     = 1'b1;
                  state_nxt = DONE;
               end else begin
                  stall_inc = 1'b1;
               end
            end else if (tx_idle) begin
               fifo_rdreq = 1'b1;
               state_nxt  = RD_WAIT;
            end
         end
         RD_WAIT: begin
            tx_load   = 1'b1;
            tx_data   = fifo_q;
            take_byte = 1'b1;
            state_nxt = PAY;
         end
         PAY: begin
            if (tx_idle) begin
               state_nxt = (cnt == len) ? CSUM : RD;
            end
         end
         CSUM: begin
            // First idle slot loads the checksum, the next one ends the frame.
            if (tx_idle) begin
               if (!csum_sent) begin
                  tx_load  = 1'b1;
                  tx_data  = csum;
                  csum_arm = 1'b1;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Frame datapath: latched length, payload count, checksum, stall timer.
   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         len       <= '0;
         cnt       <= '0;
         csum      <= '0;
         stall     <= '0;
         csum_sent <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (accept) begin
            len       <= frame_len;
            cnt       <= '0;
            csum      <= '0;
            stall     <= '0;
            csum_sent <= 1'b0;
            frame_err <= 1'b0;
         end
         if (stall_inc) begin
            stall <= stall + STALL_W'(1);
         end
         if (fifo_rdreq) begin
            stall <= '0;
         end
         if (take_byte) begin
            csum <= csum + fifo_q;
            cnt  <= cnt + 10'd1;
         end
         if (csum_arm) begin
            csum_sent <= 1'b1;
         end
         if (abort) begin
            frame_err <= 1'b1;
         end
      end
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_capture_uart_uploader.sv
// tb_capture_uart_uploader
// Scoreboard bench: each frame's expected UART bytes are queued up front from
// the framing rules; an independent UART receiver decodes txd and checks them.
module tb_capture_uart_uploader;

   localparam int unsigned DIV = 4;
   localparam int unsigned TMO = 16;
   localparam logic [7:0]  HDR = 8'hA5;

   logic       aclk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic [9:0] frame_len = '0;
   logic       fifo_empty;
   logic [7:0] fifo_q = 8'h00;
   logic       fifo_rdreq;
   logic       txd;
   logic       busy;
   logic       done;
   logic       frame_err;

   always #5 aclk = ~aclk;

   capture_uart_uploader #(
      .CLK_DIV  (DIV),
      .HDR_BYTE (HDR),
      .TIMEOUT  (TMO)
   ) dut (
      .aclk       (aclk),
      .rstn       (rstn),
      .start      (start),
      .frame_len  (frame_len),
      .fifo_empty (fifo_empty),
      .fifo_q     (fifo_q),
      .fifo_rdreq (fifo_rdreq),
      .txd        (txd),
      .busy       (busy),
      .done       (done),
      .frame_err  (frame_err)
   );

   // Capture FIFO model: non-show-ahead, one-cycle read latency.
   logic [7:0]  fifo_arr [0:1023];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge aclk) begin
      if (fifo_rdreq && !fifo_empty) begin
         fifo_q <= fifo_arr[rd_ptr % 1024];
         rd_ptr <= rd_ptr + 1;
      end
   end

   int          checks = 0;
   int          failures = 0;
   int unsigned rd_cnt = 0;
   int unsigned done_cnt = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  pay [$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   // Read-strobe legality and pulse counting.
   initial begin : rd_watch
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge aclk);
         if (done) done_cnt++;
         if (fifo_rdreq) begin
            rd_cnt++;
            checks++;
            if (fifo_empty || prev) begin
               failures++;
               $display("FAIL rdreq_legal: empty=%0b back_to_back=%0b expected 0/0", fifo_empty, prev);
            end
         end
         prev = fifo_rdreq;
      end
   end

   // UART receiver: samples mid-bit, drops any byte cut short by reset.
   initial begin : uart_mon
      logic [7:0] rx;
      logic [7:0] want;
      logic       stop_bit;
      bit         ok;
      forever begin
         @(negedge aclk);
         if (rstn && (txd == 1'b0)) begin
            ok = 1'b1;
            rx = '0;
            stop_bit = 1'b0;
            for (int b = 0; b < 10 && ok; b++) begin
               for (int k = 0; k < ((b == 0) ? DIV / 2 : DIV); k++) begin
                  @(negedge aclk);
                  if (!rstn) ok = 1'b0;
               end
               if (ok) begin
                  if (b == 0 && txd != 1'b0) ok = 1'b0;
                  else if (b >= 1 && b <= 8) rx[b-1] = txd;
                  else if (b == 9) stop_bit = txd;
               end
            end
            if (ok) begin
               chk("uart_stop_bit", stop_bit, 1);
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL uart_byte: got 0x%0h expected no byte", rx);
               end else begin
                  want = exp_q.pop_front();
                  if (rx != want) begin
                     failures++;
                     $display("FAIL uart_byte: got 0x%0h expected 0x%0h", rx, want);
                  end
               end
            end
         end
      end
   end

   task automatic fill_fifo(input int n);
      for (int i = 0; i < n; i++) begin
         fifo_arr[wr_ptr % 1024] = pay[i];
         wr_ptr = wr_ptr + 1;
      end
   endtask

   // Reference: header, length hi/lo, the payload bytes the FIFO can supply,
   // and the payload sum mod 256 only when the full length was available.
   task automatic run_frame(input int len, input int avail, input bit spurious);
      int          nsend;
      int unsigned sum;
      bit          under;
      int unsigned d0, r0, t, bound;
      logic [9:0]  l10;
      l10   = len[9:0];
      under = (avail < len);
      nsend = under ? avail : len;
      exp_q.push_back(HDR);
      exp_q.push_back({6'b000000, l10[9:8]});
      exp_q.push_back(l10[7:0]);
      sum = 0;
      for (int i = 0; i < nsend; i++) begin
         exp_q.push_back(pay[i]);
         sum += pay[i];
      end
      if (!under) exp_q.push_back(8'(sum % 256));
      d0 = done_cnt;
      r0 = rd_cnt;
      @(negedge aclk);
      start = 1'b1;
      frame_len = l10;
      @(negedge aclk);
      start = 1'b0;
      frame_len = 10'($urandom);
      if (spurious) begin
         repeat (60) @(negedge aclk);
         start = 1'b1;
         frame_len = 10'd7;
         @(negedge aclk);
         start = 1'b0;
      end
      bound = (len + 6) * 10 * DIV + 4 * len + TMO + 200;
      t = 0;
      while (done_cnt == d0 && t < bound) begin
         @(negedge aclk);
         t++;
      end
      t = 0;
      while (exp_q.size() != 0 && t < 60) begin
         @(negedge aclk);
         t++;
      end
      repeat (4) @(negedge aclk);
      chk("done_pulses", done_cnt - d0, 1);
      chk("busy_after", busy, 0);
      chk("frame_err", frame_err, under ? 1 : 0);
      chk("rdreq_count", rd_cnt - r0, nsend);
      chk("bytes_missing", exp_q.size(), 0);
      chk("fifo_left", wr_ptr - rd_ptr, avail - nsend);
      wr_ptr = rd_ptr;
      exp_q.delete();
   endtask

   initial begin : stim
      int len, avail;
      repeat (3) @(negedge aclk);
      chk("reset_txd", txd, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_rdreq", fifo_rdreq, 0);
      rstn = 1'b1;
      repeat (3) @(negedge aclk);

      // basic three-byte frame
      pay = '{8'h10, 8'h20, 8'h30};
      fill_fifo(3);
      run_frame(3, 3, 0);

      // checksum wrap; a third FIFO byte must stay unread
      pay = '{8'hFF, 8'h02, 8'h77};
      fill_fifo(3);
      run_frame(2, 3, 0);

      // empty payload
      pay.delete();
      run_frame(0, 0, 0);

      // underflow after one byte
      pay = '{8'h5C, 8'h11, 8'h22, 8'h33};
      fill_fifo(1);
      run_frame(4, 1, 0);

      // start pulse mid-frame is ignored
      pay = '{8'h10, 8'h20, 8'h30};
      fill_fifo(3);
      run_frame(3, 3, 1);

      // reset during the third header bit, then a clean frame
      pay = '{8'h10, 8'h20, 8'h30};
      fill_fifo(3);
      @(negedge aclk);
      start = 1'b1;
      frame_len = 10'd3;
      @(negedge aclk);
      start = 1'b0;
      repeat (10) @(negedge aclk);
      chk("hdr_bit1_txd", txd, 0);
      rstn = 1'b0;
      #1;
      chk("rst_mid_txd", txd, 1);
      chk("rst_mid_busy", busy, 0);
      repeat (6) @(negedge aclk);
      rstn = 1'b1;
      repeat (5) @(negedge aclk);
      chk("rst_fifo_untouched", wr_ptr - rd_ptr, 3);
      run_frame(3, 3, 0);

      // randomized frames, some underflowing, some with a spare FIFO byte
      for (int f = 0; f < 8; f++) begin
         len = $urandom_range(0, 12);
         if (f == 7) len = $urandom_range(30, 60);
         avail = len;
         if (len > 0 && $urandom_range(0, 3) == 0) avail = $urandom_range(0, len - 1);
         else if ($urandom_range(0, 3) == 0) avail = len + 1;
         pay.delete();
         for (int i = 0; i < avail; i++) pay.push_back(8'($urandom));
         fill_fifo(avail);
         run_frame(len, avail, 0);
      end

      repeat (20) @(negedge aclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
